// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data memory responder: 64-bit RAM plus MMIO console TX FIFO and mtime
// Optional misaligned-access trap is built in when DMEM_MISALIGN_TRAP_EN is defined.
module dmem_responder #(
  parameter int          DEPTH_LOG2 = 12,
  parameter logic [63:0] MMIO_BASE  = 64'h0000_0000_1000_0000,
  parameter int          FIFO_LOG2  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] daddr,
  input  logic [63:0] wdata,
  input  logic        memrw,
  input  logic [1:0]  memword,
  output logic [63:0] ddata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        misalign
);
  localparam int PW = FIFO_LOG2 + 1;

  logic [2:0]            size_mask;
  logic [7:0]            lane_mask;
  logic [63:0]           data_mask;
  logic [2:0]            offs;
  logic [7:0]            byte_en;
  logic [63:0]           wdata_sh;
  logic                  mmio_hit;
  logic [4:0]            reg_sel;
  logic                  store;
  logic [DEPTH_LOG2-1:0] row;

  logic [63:0] mem [2**DEPTH_LOG2];
  logic [7:0]  fifo [2**FIFO_LOG2];

  logic [PW-1:0] rd_ptr, wr_ptr, count;
  logic          empty, full, overflow;
  logic          pop, push_req, push, ovf_set, ovf_clr;
  logic [63:0]   mtime, status, mmio_row, rd_row;
  logic          mtime_wr;

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw,
                                        input logic [7:0] be);
    logic [63:0] r;
    r = old;
    for (int i = 0; i < 8; i++)
      if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  always_comb begin
    size_mask = 3'd0;
    lane_mask = 8'h01;
    case (memword)
      2'b00: begin size_mask = 3'd0; lane_mask = 8'h01; end
      2'b01: begin size_mask = 3'd1; lane_mask = 8'h03; end
      2'b10: begin size_mask = 3'd3; lane_mask = 8'h0f; end
      default: begin size_mask = 3'd7; lane_mask = 8'hff; end
    endcase
    data_mask = '0;
    for (int i = 0; i < 8; i++)
      data_mask[8*i +: 8] = {8{lane_mask[i]}};
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  assign misalign = rst && ((daddr[2:0] & size_mask) != 3'd0);
  assign offs     = daddr[2:0];
`else
  // Without the trap, accesses silently round down to natural alignment.
  assign misalign = 1'b0;
  assign offs     = daddr[2:0] & ~size_mask;
`endif

  assign byte_en  = lane_mask << offs;
  assign wdata_sh = wdata << {offs, 3'b000};
  assign mmio_hit = daddr[63:8] == MMIO_BASE[63:8];
  assign reg_sel  = daddr[7:3];
  assign row      = daddr[DEPTH_LOG2+2:3];
  assign store    = rst && memrw && !misalign;

  always_ff @(posedge clk)
    if (store && !mmio_hit)
      mem[row] <= merge(mem[row], wdata_sh, byte_en);

  assign count    = wr_ptr - rd_ptr;
  assign empty    = count == '0;
  assign full     = count[FIFO_LOG2];
  assign tx_valid = !empty;
  assign tx_data  = empty ? 8'h00 : fifo[rd_ptr[FIFO_LOG2-1:0]];
  assign pop      = tx_valid && tx_ready;
  assign push_req = store && mmio_hit && reg_sel == 5'd0;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push     = push_req && (!full || pop);
  assign ovf_set  = push_req && full && !pop;
  assign ovf_clr  = store && mmio_hit && reg_sel == 5'd1 && wdata[2];
  assign mtime_wr = store && mmio_hit && reg_sel == 5'd2;

  always_ff @(posedge clk)
    if (push)
      fifo[wr_ptr[FIFO_LOG2-1:0]] <= wdata[7:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      overflow <= 1'b0;
      mtime    <= '0;
    end else begin
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
      mtime <= mtime_wr ? merge(mtime, wdata_sh, byte_en) : mtime + 64'd1;
    end
  end

  always_comb begin
    status          = '0;
    status[0]       = empty;
    status[1]       = full;
    status[2]       = overflow;
    status[8 +: PW] = count;
    case (reg_sel)
      5'd1:    mmio_row = status;
      5'd2:    mmio_row = mtime;
      default: mmio_row = '0;
    endcase
    rd_row = mmio_hit ? mmio_row : mem[row];
    ddata  = misalign ? 64'd0 : ((rd_row >> {offs, 3'b000}) & data_mask);
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder (loads and console drain)
module tb_dmem_responder;
  localparam logic [63:0] MB = 64'h0000_0000_1000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] daddr = '0, wdata = '0;
  logic        memrw = 1'b0;
  logic [1:0]  memword = 2'b00;
  logic        tx_ready = 1'b0;
  logic [63:0] ddata;
  logic [7:0]  tx_data;
  logic        tx_valid, misalign;

  always #5 clk = ~clk;

  dmem_responder dut (
    .clk(clk), .rst(rst), .daddr(daddr), .wdata(wdata), .memrw(memrw),
    .memword(memword), .ddata(ddata), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .misalign(misalign)
  );

  typedef struct {
    string       name;
    logic [63:0] exp;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  tx_q[$];
  logic        chk_en = 1'b0;
  int          checks = 0;
  int          errors = 0;
  logic [63:0] row8;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares ddata on flagged load cycles and every accepted console byte.
  always @(negedge clk) begin
    exp_t       e;
    logic [7:0] b;
    if (chk_en) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_load: got %h expected no load", ddata);
      end else begin
        e = exp_q.pop_front();
        check(e.name, ddata, e.exp);
      end
    end
    if (tx_valid && tx_ready) begin
      if (tx_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL tx_extra: got %h expected no byte", tx_data);
      end else begin
        b = tx_q.pop_front();
        check("tx_order", 64'(tx_data), 64'(b));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [63:0] a, input logic [63:0] d, input logic [1:0] sz);
    daddr = a; wdata = d; memword = sz; memrw = 1'b1;
    tick();
    memrw = 1'b0;
  endtask

  task automatic load(input string name, input logic [63:0] a, input logic [1:0] sz,
                      input logic [63:0] exp);
    exp_t e;
    daddr = a; memword = sz; memrw = 1'b0;
    e.name = name; e.exp = exp;
    exp_q.push_back(e);
    chk_en = 1'b1;
    tick();
    chk_en = 1'b0;
  endtask

  task automatic push_tx(input logic [7:0] b, input bit accepted);
    if (accepted) tx_q.push_back(b);
    store(MB, {56'h0, b}, 2'b00);
  endtask

  task automatic drain(input string name);
    int n = 0;
    tx_ready = 1'b1;
    while (tx_valid && n < 40) begin
      tick();
      n++;
    end
    tx_ready = 1'b0;
    check({name, "_tx_valid"}, 64'(tx_valid), 64'd0);
    check({name, "_sb_left"}, 64'(tx_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    daddr = 64'h41; memword = 2'b01;
    #3;
    check("rst_tx_valid", 64'(tx_valid), 64'd0);
    check("rst_tx_data", 64'(tx_data), 64'd0);
    check("rst_misalign", 64'(misalign), 64'd0);
    #14 rst = 1'b1;
    repeat (3) tick();
    load("mtime_elapsed", MB + 64'h10, 2'b11, 64'd3);

    store(64'h40, 64'h1122_3344_5566_7788, 2'b11);
    store(64'h43, 64'hAA, 2'b00);
    load("ram_word40", 64'h40, 2'b10, 64'h0000_0000_AA66_7788);
    load("ram_byte47", 64'h47, 2'b00, 64'h11);
    load("ram_byte43", 64'h43, 2'b00, 64'hAA);
    load("ram_half46", 64'h46, 2'b01, 64'h1122);
    load("ram_alias", 64'h8040, 2'b11, 64'h1122_3344_AA66_7788);

    daddr = 64'h41; wdata = 64'hBEEF; memword = 2'b01; memrw = 1'b1;
    #2;
`ifdef DMEM_MISALIGN_TRAP_EN
    check("misalign_flag", 64'(misalign), 64'd1);
    tick(); memrw = 1'b0;
    load("misalign_ddata", 64'h41, 2'b01, 64'd0);
    row8 = 64'h1122_3344_AA66_7788;
`else
    check("misalign_flag", 64'(misalign), 64'd0);
    tick(); memrw = 1'b0;
    load("round_down_half", 64'h41, 2'b01, 64'hBEEF);
    row8 = 64'h1122_3344_AA66_BEEF;
`endif
    load("row8_after_half", 64'h40, 2'b11, row8);

    load("status_empty", MB + 64'h8, 2'b11, 64'h1);
    for (int i = 0; i < 8; i++) push_tx(8'h10 + 8'(i), 1'b1);
    load("status_full", MB + 64'h8, 2'b11, 64'h802);
    push_tx(8'h18, 1'b0);
    load("status_ovf", MB + 64'h8, 2'b11, 64'h806);
    store(MB + 64'h8, 64'h4, 2'b11);
    load("status_ovf_clr", MB + 64'h8, 2'b11, 64'h802);
    tx_ready = 1'b1;
    push_tx(8'h20, 1'b1);
    tx_ready = 1'b0;
    load("status_push_pop", MB + 64'h8, 2'b11, 64'h802);
    load("status_byte9", MB + 64'h9, 2'b00, 64'h08);
    load("txdata_load", MB, 2'b11, 64'd0);
    load("unmapped_load", MB + 64'h18, 2'b11, 64'd0);
    drain("drain1");
    load("status_drained", MB + 64'h8, 2'b11, 64'h1);

    store(MB + 64'h10, 64'h100, 2'b11);
    load("mtime_written", MB + 64'h10, 2'b11, 64'h100);
    repeat (5) tick();
    load("mtime_plus6", MB + 64'h10, 2'b11, 64'h106);
    store(MB + 64'h12, 64'hBEEF, 2'b01);
    load("mtime_half_merge", MB + 64'h10, 2'b11, 64'hBEEF_0107);
    load("mtime_byte13", MB + 64'h13, 2'b00, 64'hBE);
    store(MB + 64'h10, 64'hFFFF_FFFF_FFFF_FFFF, 2'b11);
    load("mtime_max", MB + 64'h10, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF);
    load("mtime_wrap", MB + 64'h10, 2'b11, 64'd0);

    push_tx(8'h31, 1'b1);
    push_tx(8'h32, 1'b1);
    push_tx(8'h33, 1'b1);
    tx_ready = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("async_rst_tx_valid", 64'(tx_valid), 64'd0);
    check("async_rst_tx_data", 64'(tx_data), 64'd0);
    tx_q.delete();
    tx_ready = 1'b0;
    store(64'h40, 64'hDEAD, 2'b11);
    store(MB, 64'h55, 2'b00);
    rst = 1'b1;
    load("status_post_reset", MB + 64'h8, 2'b11, 64'h1);
    load("rst_store_ignored", 64'h40, 2'b11, row8);

    tx_q.push_back(8'h44);
    daddr = MB; wdata = 64'h44; memword = 2'b00; memrw = 1'b1;
    #2;
    check("no_bypass", 64'(tx_valid), 64'd0);
    tick(); memrw = 1'b0;
    check("tx_valid_next", 64'(tx_valid), 64'd1);
    check("tx_head_after_reset", 64'(tx_data), 64'h44);
    drain("drain2");

    check("loads_consumed", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
